// File: rtl/hazard_forward_unit.sv
// Hazard resolution for the five-stage pipeline: operand forwarding selects,
// counted load-use stall, counted branch flush and saturating debug counters.
module hazard_forward_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_STALL   = 2,
   parameter int BRANCH_FLUSH = 1,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] mw_rd,
   input  logic                  mw_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic                  branch_taken,
   input  logic                  cnt_clear,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall_if_id,
   output logic                  bubble_id_ex,
   output logic                  flush_if_id,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_cycles,
   output logic [CNT_W-1:0]      load_use_events
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   localparam logic [3:0] LS_INIT = 4'(LOAD_STALL - 1);
   localparam logic [3:0] BF_INIT = 4'(BRANCH_FLUSH - 1);
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};

   state_t           state_r;
   state_t           state_s;
   logic [3:0]       cnt_r;
   logic [3:0]       cnt_s;
   logic             hazard_s;
   logic             stall_s;
   logic             flush_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic [CNT_W-1:0] load_cnt_r;

   // Loads still in EX have no data yet, so they never forward from EX.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] src,
      input logic                  used,
      input logic [REG_ADDR_W-1:0] e_rd,
      input logic                  e_wr,
      input logic                  e_ld,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  m_wr,
      input logic [REG_ADDR_W-1:0] w_rd,
      input logic                  w_wr
   );
      logic [1:0] sel;
      if (!used || src == ZERO_REG) begin
         sel = 2'b00;
      end else if (e_wr && !e_ld && e_rd == src) begin
         sel = 2'b01;
      end else if (m_wr && m_rd == src) begin
         sel = 2'b10;
      end else if (w_wr && w_rd == src) begin
         sel = 2'b11;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
      logic [CNT_W-1:0] result;
      if (en && !(&value)) begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         result = value;
      end
      return result;
   endfunction

   // Per-operand forwarding selects, held at regfile while in reset.
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (!reset) begin
         fwd_a_sel = fwd_sel(id_rs1, id_rs1_used, ex_rd, ex_reg_write, ex_is_load,
                             mw_rd, mw_reg_write, wb_rd, wb_reg_write);
         fwd_b_sel = fwd_sel(id_rs2, id_rs2_used, ex_rd, ex_reg_write, ex_is_load,
                             mw_rd, mw_reg_write, wb_rd, wb_reg_write);
      end else begin
         fwd_a_sel = 2'b00;
         fwd_b_sel = 2'b00;
      end
   end

   // Load-use detection, only evaluated when idle.
   always_comb begin
      hazard_s = 1'b0;
      if (id_valid && state_r == IDLE && ex_is_load && ex_reg_write && ex_rd != ZERO_REG) begin
         hazard_s = (id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd);
      end else begin
         hazard_s = 1'b0;
      end
   end

   // Stall/flush sequencing; load-use beats a simultaneous branch.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      stall_s = 1'b0;
      flush_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (hazard_s) begin
               stall_s = 1'b1;
               if (LS_INIT != 4'd0) begin
                  state_s = LSTALL;
                  cnt_s   = LS_INIT;
               end else begin
                  state_s = IDLE;
               end
            end else if (branch_taken) begin
               flush_s = 1'b1;
               if (BF_INIT != 4'd0) begin
                  state_s = FLUSH;
                  cnt_s   = BF_INIT;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LSTALL, FLUSH: begin
            stall_s = (state_r == LSTALL);
            flush_s = (state_r == FLUSH);
            if (cnt_r <= 4'd1) begin
               state_s = IDLE;
               cnt_s   = 4'd0;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   assign stall_if_id  = stall_s && !reset;
   assign bubble_id_ex = stall_s && !reset;
   assign flush_if_id  = flush_s && !reset;

   // State and sequence counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Saturating debug counters; clear takes priority over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
         load_cnt_r  <= {CNT_W{1'b0}};
      end else if (cnt_clear) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
         load_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_r <= sat_inc(stall_cnt_r, stall_if_id);
         flush_cnt_r <= sat_inc(flush_cnt_r, flush_if_id);
         load_cnt_r  <= sat_inc(load_cnt_r, hazard_s);
      end
   end

   assign stall_cycles    = stall_cnt_r;
   assign flush_cycles    = flush_cnt_r;
   assign load_use_events = load_cnt_r;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard-resolution block for the five-stage pipeline (IF, ID, EX, MW, WB). It generates operand-forwarding selects for the ID-stage operand muxes, and load-use stall/bubble control via a counted stall state machine. It also generates branch-flush control via a counted flush state machine. Saturating event counters are exposed for debug display.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_STALL, 2, stall cycles inserted on load-use hazard (1..15)
BRANCH_FLUSH, 1, consecutive cycles flush_if_id is asserted after a taken branch (1..15)
CNT_W, 32, width of each event counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  ID source 1 address
id_rs2  in  REG_ADDR_W  ID source 2 address
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
ex_rd  in  REG_ADDR_W  destination of instruction in ID/EX
ex_reg_write  in  1  EX instruction writes register
ex_is_load  in  1  EX instruction is a load
mw_rd  in  REG_ADDR_W  destination in EX/MW
mw_reg_write  in  1  MW instruction writes register
wb_rd  in  REG_ADDR_W  destination in MW/WB
wb_reg_write  in  1  WB instruction writes register
branch_taken  in  1  branch resolved taken in ID
cnt_clear  in  1  synchronous clear of all counters
fwd_a_sel  out  2  rs1 source: 00 regfile, 01 EX ALU result, 10 EX/MW ALU result, 11 WB write data
fwd_b_sel  out  2  rs2 source, same encoding
stall_if_id  out  1  hold PC and IF/ID
bubble_id_ex  out  1  load NOP (reg_write=0, mem_write=0) into ID/EX
flush_if_id  out  1  squash IF/ID contents to NOP
stall_cycles  out  CNT_W  cycles with stall_if_id=1
flush_cycles  out  CNT_W  cycles with flush_if_id=1
load_use_events  out  CNT_W  load-use hazards detected

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and all counters go to 0.
  - fwd_*_sel=00. stall_if_id, bubble_id_ex and flush_if_id are 0 while reset=1, including when reset asserts mid-stall or mid-flush.
- Forwarding is combinational from the inputs. It is evaluated per operand, with fixed priority:
  - EX (11→ no, 01) if ex_reg_write and ex_rd==src and not ex_is_load.
  - Otherwise EX/MW (10) if mw_reg_write and mw_rd==src.
  - Otherwise WB (11) if wb_reg_write and wb_rd==src.
  - Otherwise 00.
  - src==0 always yields 00. An unused operand (rsN_used=0) yields 00.
- Load-use hazard:
  - Condition: id_valid, state IDLE, ex_is_load, ex_reg_write, ex_rd!=0, and ex_rd matches a used source.
  - In the detection cycle, stall_if_id=1, bubble_id_ex=1 and load_use_events increments.
  - Next state is LSTALL with counter = LOAD_STALL-1. If that value is 0, next state is IDLE.
- LSTALL:
  - stall_if_id=1, bubble_id_ex=1. The counter decrements each cycle; when it reaches 0, return to IDLE.
  - Hazard re-detection is suppressed in LSTALL.
  - Total stall length is exactly LOAD_STALL cycles.
- Branch flush:
  - branch_taken is honoured only when stall_if_id=0 in the same cycle; the unit masks it otherwise.
  - When honoured, flush_if_id=1 that cycle. Next state is FLUSH with counter = BRANCH_FLUSH-1, or IDLE if that value is 0.
- FLUSH:
  - flush_if_id=1 and the counter decrements; return to IDLE at 0.
  - Load-use detection and further branch_taken are ignored in FLUSH; the ID contents are squashed.
- Simultaneous branch_taken and load-use detection in IDLE: load-use wins, because the branch operands are unresolved. The branch is re-evaluated after the stall.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones, with no wrap.
  - cnt_clear has priority over increment. Counters are registered, so values update on the clock edge after the event.
- Forwarding outputs remain valid during LSTALL and FLUSH. They always reflect the current inputs.

Test Plan:
- x1 ALU write in EX, ID reads rs1=1, rs2=1 → fwd_a_sel=fwd_b_sel=01. Same with ex_rd=0 → 00.
- x5 in both EX/MW and WB, ID rs2=5 → fwd_b_sel=10. Retire the MW write → 11.
- Load to x3 in EX, ID uses rs1=3, LOAD_STALL=2 → stall_if_id and bubble_id_ex high for exactly 2 cycles; load_use_events=1. When WB then holds x3, fwd_a_sel=11.
- branch_taken pulse with BRANCH_FLUSH=3 → flush_if_id high for 3 cycles; flush_cycles=3. A load-use pattern during the flush → no stall.
- branch_taken together with a load-use in IDLE → stall taken, no flush. branch_taken asserted during LSTALL → ignored.
- Assert reset during LSTALL → outputs drop to 0 immediately. Preset stall_cycles to all-ones via force → stays saturated. cnt_clear → 0 next edge.
